// File: rtl/clock_sync_multi_if.sv
// Bus-side signals of clock_sync_multi: the async MCCLK and strobe pins with their
// per-channel configuration, and the SYSCLK-domain results handed to the bus state machine.
interface clock_sync_multi_if #(
    parameter int NUM_IN   = 4,
    parameter int DELAY_W  = 5,
    parameter int PERIOD_W = 6
);
    logic                      MCCLK;
    logic [NUM_IN-1:0]         IN;
    logic [NUM_IN*DELAY_W-1:0] DELAY;
    logic [NUM_IN*2-1:0]       MODE;
    logic                      MCCLK_FALLING;
    logic                      MCCLK_RISING;
    logic [PERIOD_W-1:0]       MC_PHASE;
    logic [PERIOD_W-1:0]       MC_PERIOD;
    logic                      PERIOD_VALID;
    logic [NUM_IN-1:0]         LEVEL;
    logic [NUM_IN-1:0]         EVENT;

    modport master (
        output MCCLK, IN, DELAY, MODE,
        input  MCCLK_FALLING, MCCLK_RISING, MC_PHASE, MC_PERIOD, PERIOD_VALID, LEVEL, EVENT
    );

    modport slave (
        input  MCCLK, IN, DELAY, MODE,
        output MCCLK_FALLING, MCCLK_RISING, MC_PHASE, MC_PERIOD, PERIOD_VALID, LEVEL, EVENT
    );
endinterface

// File: rtl/clock_sync_multi.sv
// Brings MCCLK and NUM_IN active-low bus strobes into the SYSCLK domain (falling-edge logic),
// measures the MCCLK period/phase and delays each strobe through a programmable tap.
module clock_sync_multi #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_IN      = 4,
    parameter int DEPTH       = 32,
    parameter int DELAY_W     = 5,
    parameter int PERIOD_W    = 6
) (
    input  logic              SYSCLK,
    input  logic              nRESET,
    clock_sync_multi_if.slave bus
);
    localparam logic [PERIOD_W-1:0] PHASE_MAX = '1;
    localparam logic [DELAY_W-1:0]  TAP_MAX   = DELAY_W'(DEPTH - 1);

    // MCCLK chain carries one extra history stage beyond the synchroniser for edge detection
    logic [SYNC_STAGES:0]   mc_sync_q, mc_sync_d;
    logic                   mc_fall_q, mc_fall_d;
    logic                   mc_rise_q, mc_rise_d;
    logic [PERIOD_W-1:0]    phase_q, phase_d;
    logic [PERIOD_W-1:0]    period_q, period_d;
    logic [PERIOD_W:0]      period_sum;
    logic                   valid_q, valid_d;
    logic                   seen_q, seen_d;

    logic [SYNC_STAGES-1:0] in_sync_q [NUM_IN];
    logic [SYNC_STAGES-1:0] in_sync_d [NUM_IN];
    logic [DEPTH-2:0]       dl_q      [NUM_IN];
    logic [DEPTH-2:0]       dl_d      [NUM_IN];
    logic [DELAY_W-1:0]     dsel_q    [NUM_IN];
    logic [DELAY_W-1:0]     dsel_d    [NUM_IN];
    logic [NUM_IN-1:0]      level_q, level_d;
    logic [NUM_IN-1:0]      event_q, event_d;

    logic [DELAY_W-1:0]     dly_raw   [NUM_IN];
    logic                   tap_val   [NUM_IN];

    for (genvar c = 0; c < NUM_IN; c++) begin : g_tap
        logic [DEPTH-1:0]   line;
        logic [DELAY_W-1:0] sel;
        assign dly_raw[c] = bus.DELAY[c*DELAY_W +: DELAY_W];
        assign sel        = (32'(dly_raw[c]) >= 32'(DEPTH)) ? TAP_MAX : dly_raw[c];
        // Tap 0 is the synchroniser output, tap k is k cycles behind it
        assign line       = {dl_q[c], in_sync_q[c][SYNC_STAGES-1]};
        assign tap_val[c] = line[sel];
    end

    always_comb begin
        mc_sync_d  = {mc_sync_q[SYNC_STAGES-1:0], bus.MCCLK};
        mc_fall_d  =  mc_sync_q[SYNC_STAGES] & ~mc_sync_q[SYNC_STAGES-1];
        mc_rise_d  = ~mc_sync_q[SYNC_STAGES] &  mc_sync_q[SYNC_STAGES-1];
        period_sum = {1'b0, phase_q} + (PERIOD_W+1)'(1);
        phase_d    = phase_q;
        period_d   = period_q;
        valid_d    = valid_q;
        seen_d     = seen_q;
        if (mc_fall_d) begin
            phase_d = '0;
            if (seen_q) begin
                period_d = period_sum[PERIOD_W] ? PHASE_MAX : period_sum[PERIOD_W-1:0];
            end
            valid_d = seen_q && (phase_q != PHASE_MAX);
            seen_d  = 1'b1;
        end else begin
            if (phase_q != PHASE_MAX) begin
                phase_d = phase_q + PERIOD_W'(1);
            end
            // A stalled MCCLK invalidates the measurement as soon as the phase saturates
            if (phase_d == PHASE_MAX) begin
                valid_d = 1'b0;
            end
        end
    end

    always_comb begin
        in_sync_d = in_sync_q;
        dl_d      = dl_q;
        dsel_d    = dsel_q;
        level_d   = level_q;
        event_d   = '0;
        for (int c = 0; c < NUM_IN; c++) begin
            in_sync_d[c] = {in_sync_q[c][SYNC_STAGES-2:0], bus.IN[c]};
            dl_d[c]      = {dl_q[c][DEPTH-3:0], in_sync_q[c][SYNC_STAGES-1]};
            dsel_d[c]    = dly_raw[c];
            level_d[c]   = tap_val[c];
            // A tap switch reloads LEVEL silently; only real edges on a stable tap raise EVENT
            if (dly_raw[c] == dsel_q[c]) begin
                event_d[c] = (level_q[c] & ~level_d[c] & bus.MODE[2*c]) |
                             (~level_q[c] & level_d[c] & bus.MODE[2*c+1]);
            end
        end
    end

    always_ff @(negedge SYSCLK or negedge nRESET) begin
        if (!nRESET) begin
            mc_sync_q <= '0;
            mc_fall_q <= 1'b0;
            mc_rise_q <= 1'b0;
            phase_q   <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            seen_q    <= 1'b0;
            in_sync_q <= '{default: '1};
            dl_q      <= '{default: '1};
            dsel_q    <= '{default: '0};
            level_q   <= '1;
            event_q   <= '0;
        end else begin
            mc_sync_q <= mc_sync_d;
            mc_fall_q <= mc_fall_d;
            mc_rise_q <= mc_rise_d;
            phase_q   <= phase_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            seen_q    <= seen_d;
            in_sync_q <= in_sync_d;
            dl_q      <= dl_d;
            dsel_q    <= dsel_d;
            level_q   <= level_d;
            event_q   <= event_d;
        end
    end

    assign bus.MCCLK_FALLING = mc_fall_q;
    assign bus.MCCLK_RISING  = mc_rise_q;
    assign bus.MC_PHASE      = phase_q;
    assign bus.MC_PERIOD     = period_q;
    assign bus.PERIOD_VALID  = valid_q;
    assign bus.LEVEL         = level_q;
    assign bus.EVENT         = event_q;
endmodule

// File: tb/tb_clock_sync_multi.sv
// Bench for clock_sync_multi: inputs change half a SYSCLK period away from the falling edge,
// a timestamp/history model predicts every output each cycle.
module tb_clock_sync_multi;
  localparam int S     = 2;
  localparam int N     = 4;
  localparam int DEPTH = 24;
  localparam int DW    = 5;
  localparam int PW    = 6;
  localparam int PMAX  = (1 << PW) - 1;
  localparam int EW    = 2*N + 2*PW + 3;

  logic SYSCLK = 1'b0;
  logic nRESET;

  clock_sync_multi_if #(.NUM_IN(N), .DELAY_W(DW), .PERIOD_W(PW)) bus ();

  clock_sync_multi #(
    .SYNC_STAGES(S), .NUM_IN(N), .DEPTH(DEPTH), .DELAY_W(DW), .PERIOD_W(PW)
  ) dut (
    .SYSCLK(SYSCLK),
    .nRESET(nRESET),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  always #5 SYSCLK = ~SYSCLK;

  // ---------------- counters / checker ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  bit               mc_h[$];
  logic [N-1:0]     in_h[$];
  logic [N*DW-1:0]  dly_h[$];
  logic [EW-1:0]    exp_q[$];
  int               last_fall, interval;
  bit               seen_m, have_two;

  function automatic bit mc_at(int i);
    if (i < 0) return 1'b0;
    return mc_h[i];
  endfunction

  function automatic bit in_at(int c, int i);
    logic [N-1:0] v;
    if (i < 0) return 1'b1;
    v = in_h[i];
    return v[c];
  endfunction

  function automatic int dsel_at(int c, int i);
    logic [N*DW-1:0] v;
    if (i < 0) return 0;
    v = dly_h[i];
    return int'(v[c*DW +: DW]);
  endfunction

  // LEVEL after edge k shows the input sampled S+D edges earlier, D = clamped current tap
  function automatic bit lvl_at(int c, int k);
    int d;
    if (k < 0) return 1'b1;
    d = dsel_at(c, k);
    if (d > DEPTH - 1) d = DEPTH - 1;
    return in_at(c, k - S - d);
  endfunction

  int             m_k, m_since, m_phase, m_period;
  bit             m_fall, m_rise, m_valid, m_l, m_lp;
  logic [N-1:0]   m_lv, m_ev;
  logic [1:0]     m_mode;

  always @(negedge SYSCLK) begin
    if (!nRESET) begin
      mc_h.delete();
      in_h.delete();
      dly_h.delete();
      last_fall = -1;
      interval  = 0;
      seen_m    = 1'b0;
      have_two  = 1'b0;
      exp_q.push_back({2'b00, PW'(0), PW'(0), 1'b0, {N{1'b1}}, {N{1'b0}}});
    end else begin
      mc_h.push_back(bus.MCCLK);
      in_h.push_back(bus.IN);
      dly_h.push_back(bus.DELAY);
      m_k    = mc_h.size() - 1;
      m_fall =  mc_at(m_k - S - 1) && !mc_at(m_k - S);
      m_rise = !mc_at(m_k - S - 1) &&  mc_at(m_k - S);
      if (m_fall) begin
        if (seen_m) begin
          interval = m_k - last_fall;
          have_two = 1'b1;
        end
        seen_m    = 1'b1;
        last_fall = m_k;
      end
      m_since  = m_k - last_fall;
      m_phase  = (m_since > PMAX) ? PMAX : m_since;
      m_period = have_two ? ((interval > PMAX) ? PMAX : interval) : 0;
      m_valid  = have_two && (interval <= PMAX) && (m_since < PMAX);
      for (int c = 0; c < N; c++) begin
        m_l      = lvl_at(c, m_k);
        m_lp     = lvl_at(c, m_k - 1);
        m_mode   = bus.MODE[2*c +: 2];
        m_lv[c]  = m_l;
        m_ev[c]  = (dsel_at(c, m_k) == dsel_at(c, m_k - 1)) &&
                   ((m_lp && !m_l && m_mode[0]) || (!m_lp && m_l && m_mode[1]));
      end
      exp_q.push_back({m_fall, m_rise, PW'(m_phase), PW'(m_period), m_valid, m_lv, m_ev});
    end
  end

  // ---------------- scoreboard compare (opposite edge) ----------------
  logic [EW-1:0] exp_v;

  always @(posedge SYSCLK) begin
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      check_val("mc_falling",   32'(bus.MCCLK_FALLING), 32'(exp_v[EW-1]));
      check_val("mc_rising",    32'(bus.MCCLK_RISING),  32'(exp_v[EW-2]));
      check_val("mc_phase",     32'(bus.MC_PHASE),      32'(exp_v[2*N+2*PW : 2*N+PW+1]));
      check_val("mc_period",    32'(bus.MC_PERIOD),     32'(exp_v[2*N+PW : 2*N+1]));
      check_val("period_valid", 32'(bus.PERIOD_VALID),  32'(exp_v[2*N]));
      check_val("level",        32'(bus.LEVEL),         32'(exp_v[2*N-1 : N]));
      check_val("event",        32'(bus.EVENT),         32'(exp_v[N-1 : 0]));
    end
  end

  // ---------------- drivers ----------------
  int mc_mode, mc_per, mc_cnt;

  task automatic tick();
    @(posedge SYSCLK);
    #1;
    case (mc_mode)
      0: begin
        mc_cnt    = (mc_cnt + 1) % mc_per;
        bus.MCCLK = (mc_cnt >= mc_per / 2);
      end
      1: ;
      default: if ($urandom_range(0, 3) == 0) bus.MCCLK = ~bus.MCCLK;
    endcase
  endtask

  int n_ev0, n_ev1, n_ev2, n_ev3, at0, first2, gap2;

  initial begin
    nRESET    = 1'b0;
    bus.MCCLK = 1'b0;
    bus.IN    = '0;
    bus.DELAY = '0;
    bus.MODE  = '1;
    mc_mode   = 0;
    mc_per    = 4;
    mc_cnt    = 0;
    repeat (10) tick();
    nRESET = 1'b1;

    // steady 16-cycle MCCLK
    mc_per = 16;
    repeat (80) tick();
    check_val("period16_value", 32'(bus.MC_PERIOD), 32'd16);
    check_val("period16_valid", 32'(bus.PERIOD_VALID), 32'd1);

    // stall with MCCLK high
    for (int i = 0; i < 32 && bus.MCCLK == 1'b0; i++) tick();
    mc_mode = 1;
    repeat (70) tick();
    check_val("stall_phase", 32'(bus.MC_PHASE), 32'(PMAX));
    check_val("stall_valid", 32'(bus.PERIOD_VALID), 32'd0);
    check_val("stall_period", 32'(bus.MC_PERIOD), 32'd16);
    mc_mode = 0;

    // DTACK legacy: tap 15, falling-only
    bus.IN             = '1;
    bus.MODE           = {2'b11, 2'b11, 2'b11, 2'b01};
    bus.DELAY[0 +: DW] = DW'(15);
    repeat (40) tick();
    bus.IN[0] = 1'b0;
    n_ev0 = 0;
    at0   = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus.EVENT[0]) begin
        n_ev0++;
        at0 = i;
      end
    end
    check_val("dtack_count", 32'(n_ev0), 32'd1);
    check_val("dtack_latency", 32'(at0), 32'(S + 16));

    // modes and independence: ch1 rising, ch2 both, ch3 off
    bus.DELAY = '0;
    bus.MODE  = {2'b00, 2'b11, 2'b10, 2'b01};
    repeat (10) tick();
    bus.IN[3:1] = 3'b000;
    n_ev1 = 0; n_ev2 = 0; n_ev3 = 0; first2 = 0; gap2 = 0;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (i == 5) bus.IN[3:1] = 3'b111;
      if (bus.EVENT[1]) n_ev1++;
      if (bus.EVENT[3]) n_ev3++;
      if (bus.EVENT[2]) begin
        if (n_ev2 == 0) first2 = i;
        else gap2 = i - first2;
        n_ev2++;
      end
    end
    check_val("mode_rise_count", 32'(n_ev1), 32'd1);
    check_val("mode_both_count", 32'(n_ev2), 32'd2);
    check_val("mode_both_gap", 32'(gap2), 32'd5);
    check_val("mode_off_count", 32'(n_ev3), 32'd0);

    // tap change 10 -> 3 while a 0 sits between the two taps
    bus.MODE[1:0]      = 2'b11;
    bus.DELAY[0 +: DW] = DW'(10);
    bus.IN[0]          = 1'b1;
    repeat (30) tick();
    bus.IN[0] = 1'b0;
    repeat (7) tick();
    bus.DELAY[0 +: DW] = DW'(3);
    tick();
    check_val("tapchg_level", 32'(bus.LEVEL[0]), 32'd0);
    check_val("tapchg_event", 32'(bus.EVENT[0]), 32'd0);
    repeat (20) tick();
    bus.IN[0] = 1'b1;
    n_ev0 = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.EVENT[0]) n_ev0++;
    end
    check_val("tapchg_real_edge", 32'(n_ev0), 32'd1);

    // randomized traffic with a mid-run reset
    for (int it = 0; it < 1500; it++) begin
      tick();
      if (it % 300 == 0) begin
        mc_mode = $urandom_range(0, 2);
        mc_per  = 2 * $urandom_range(2, 20);
      end
      if (it == 800) nRESET = 1'b0;
      if (it == 803) nRESET = 1'b1;
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 7) == 0)  bus.IN[c] = ~bus.IN[c];
        if ($urandom_range(0, 39) == 0) bus.DELAY[c*DW +: DW] = DW'($urandom_range(0, 31));
        if ($urandom_range(0, 59) == 0) bus.MODE[2*c +: 2] = 2'($urandom_range(0, 3));
      end
    end
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
